ex_muldiv: RTL and testbench
============================

Name: ex_muldiv

Overview:
Iterative RV32M/RV64M multiply/divide unit attached beside the single-cycle EX ALU.
- Accepts one M-extension op at a time over a valid/ready request channel.
- Computes the result over several cycles and returns it, with its destination register index, over a valid/ready result channel.
- Honours the pipeline flush raised by branch resolution.
- Parametrised in data width and bits retired per cycle.

Parameters:
- XLEN, 32, operand/result width; 32 or 64.
- REG_IDX_WIDTH, 5, destination register index width.
- STEP, 1, bits of multiplier/quotient processed per cycle; 1 or 2; XLEN % STEP == 0.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- flush_i  in  1  pipeline flush; aborts any op in flight.
- req_valid_i  in  1  request valid.
- req_ready_o  out  1  unit can accept a request.
- req_fun3_i  in  3  M-op select: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- req_rs1_i  in  XLEN  operand 1 (multiplicand / dividend).
- req_rs2_i  in  XLEN  operand 2 (multiplier / divisor).
- req_rd_idx_i  in  REG_IDX_WIDTH  destination register.
- res_valid_o  out  1  result valid.
- res_ready_i  in  1  consumer accepts result.
- res_data_o  out  XLEN  result.
- res_rd_idx_o  out  REG_IDX_WIDTH  destination of result.
- busy_o  out  1  state != IDLE.

Behaviour:
- Reset (rst_n low, asynchronous):
  - State goes to IDLE.
  - res_valid_o, res_data_o, res_rd_idx_o, the counter and all datapath registers are cleared to 0.
  - req_ready_o = 1 and busy_o = 0 during and after reset.
- States:
  - IDLE: req_ready_o = 1 only here.
  - CALC: iterative computation.
  - FIX: sign correction and result select.
  - DONE: result held.
- Accept: on a clock edge with req_valid_i & req_ready_o & ~flush_i, latch fun3, rd_idx and the operands.
  - Signed operands are latched as absolute values.
  - Result sign is recorded:
    - MUL/MULH: sign(rs1) ^ sign(rs2).
    - MULHSU: sign(rs1).
    - DIV: sign(rs1) ^ sign(rs2).
    - REM: sign(rs1).
  - Unsigned ops record a positive sign.
- Special cases at accept go straight to DONE; res_valid_o is high 1 cycle after the accept edge:
  - DIV/DIVU, rs2 == 0: quotient = all ones; REM/REMU result = rs1.
  - DIV, rs1 == most-negative and rs2 == all ones: quotient = rs1; REM result = 0.
- Normal path goes to CALC; the counter loads XLEN/STEP - 1 (width $clog2(XLEN/STEP), minimum 1).
- CALC, multiply: STEP shift-add steps per cycle into a 2*XLEN accumulator, LSB-first.
- CALC, divide: STEP restoring-division steps per cycle, MSB-first; partial remainder is XLEN+1 bits.
- CALC ends when the counter reaches 0; the next state is FIX.
- FIX:
  - Negate the 2*XLEN product or the quotient/remainder (two's complement) if the recorded sign is negative.
  - Select the output: MUL gives the low half; MULH/MULHSU/MULHU give the high half; DIV/DIVU give the quotient; REM/REMU give the remainder.
  - Register the selection into res_data_o. Next state is DONE.
- Normal latency: res_valid_o rises XLEN/STEP + 2 cycles after the accept edge (34 cycles for XLEN=32, STEP=1).
- DONE: res_valid_o = 1; res_data_o and res_rd_idx_o are stable until res_valid_o & res_ready_i, then the state returns to IDLE.
  - No new request is accepted in the handshake cycle, so the minimum request-to-request spacing is latency + 1.
- Flush: flush_i has priority over all events.
  - From any state, the next state is IDLE and res_valid_o is 0 the following cycle.
  - A request presented in the same cycle as a flush is dropped.
  - A result handshake in the same cycle as a flush still completes; the consumer owns killing it.
- Iteration and negation arithmetic wraps modulo its declared width; no internal overflow is possible.

Decomposition:
- The shared defines header gains:
  - M-op funct3 constants MUL…REMU.
  - FUNCT7_MULDIV = 7'b0000001.
  - An ex_muldiv state encoding (IDLE/CALC/FIX/DONE).
- The decode stage uses opcode INSTR_AL with FUNCT7_MULDIV to steer ops here instead of the ALU.
- One sub-module, muldiv_step: a combinational single-bit iteration (shift-add or restore-subtract, selected by a mode bit). It is instantiated STEP times in a chain.

Test Plan:
- XLEN=32, STEP=1. MUL rs1=7, rs2=0xFFFFFFFD, rd=5 -> res_valid_o 34 cycles after accept; res_data_o=0xFFFFFFEB, res_rd_idx_o=5.
- MULH 0x80000000 x 0x80000000 -> 0x40000000. MULHSU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFF. MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE.
- DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000 after 1 cycle; REM on the same operands -> 0. DIVU 1234/0 -> 0xFFFFFFFF; REMU 1234/0 -> 1234, both after 1 cycle.
- DIV -7/2 -> 0xFFFFFFFD; REM -7/2 -> 0xFFFFFFFF. DIVU 100/7 -> 14; REMU 100/7 -> 2.
- Flush asserted 10 cycles into a DIV -> busy_o=0 and req_ready_o=1 the next cycle. A fresh MUL 3x4 then returns 12 with correct latency; no stale result appears.
- res_ready_i held low 20 cycles in DONE -> res_valid_o and res_data_o stable throughout and req_ready_o low. Repeat DIVU 100/7 with STEP=2 -> result 14 after 18 cycles.

Source files
------------

// File: rtl/ex_muldiv_pkg.sv
// Shared definitions for the iterative M-extension unit: funct3 op codes,
// decode steering constants and the controller state encoding.
package ex_muldiv_pkg;

   localparam logic [2:0] MUL    = 3'b000;
   localparam logic [2:0] MULH   = 3'b001;
   localparam logic [2:0] MULHSU = 3'b010;
   localparam logic [2:0] MULHU  = 3'b011;
   localparam logic [2:0] DIV    = 3'b100;
   localparam logic [2:0] DIVU   = 3'b101;
   localparam logic [2:0] REM    = 3'b110;
   localparam logic [2:0] REMU   = 3'b111;

   localparam logic [6:0] INSTR_AL      = 7'b0110011;
   localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      FIX  = 2'd2,
      DONE = 2'd3
   } md_state_e;

   function automatic logic rs1_is_signed(input logic [2:0] fun3);
      return fun3 inside {MUL, MULH, MULHSU, DIV, REM};
   endfunction

   function automatic logic rs2_is_signed(input logic [2:0] fun3);
      return fun3 inside {MUL, MULH, DIV, REM};
   endfunction

endpackage

// File: rtl/ex_muldiv_step.sv
// One combinational iteration: shift-add multiply step (mode_i=0) or
// restoring-division step (mode_i=1) on the shared rem/quo register pair.
module ex_muldiv_step #(
   parameter int XLEN = 32
) (
   input  logic            mode_i,
   input  logic [XLEN-1:0] opd_i,
   input  logic [XLEN:0]   rem_i,
   input  logic [XLEN-1:0] quo_i,
   output logic [XLEN:0]   rem_o,
   output logic [XLEN-1:0] quo_o
);

   logic [XLEN:0] sum;
   logic [XLEN:0] shifted;
   logic [XLEN:0] diff;

   always_comb begin
      sum     = rem_i + (quo_i[0] ? {1'b0, opd_i} : '0);
      shifted = {rem_i[XLEN-1:0], quo_i[XLEN-1]};
      diff    = shifted - {1'b0, opd_i};
      rem_o   = '0;
      quo_o   = '0;
      if (mode_i) begin
         // borrow out of the subtract means the divisor did not fit
         if (diff[XLEN]) begin
            rem_o = shifted;
            quo_o = {quo_i[XLEN-2:0], 1'b0};
         end else begin
            rem_o = diff;
            quo_o = {quo_i[XLEN-2:0], 1'b1};
         end
      end else begin
         rem_o = {1'b0, sum[XLEN:1]};
         quo_o = {sum[0], quo_i[XLEN-1:1]};
      end
   end

endmodule

// File: rtl/ex_muldiv.sv
// Iterative RV32M/RV64M multiply/divide unit beside the EX ALU.
// state | meaning
// IDLE  | ready for a request
// CALC  | STEP iterations per cycle until the counter hits 0
// FIX   | sign correction and result select
// DONE  | result held until the consumer takes it
module ex_muldiv
   import ex_muldiv_pkg::*;
#(
   parameter int XLEN          = 32,
   parameter int REG_IDX_WIDTH = 5,
   parameter int STEP          = 1
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     flush_i,
   input  logic                     req_valid_i,
   output logic                     req_ready_o,
   input  logic [2:0]               req_fun3_i,
   input  logic [XLEN-1:0]          req_rs1_i,
   input  logic [XLEN-1:0]          req_rs2_i,
   input  logic [REG_IDX_WIDTH-1:0] req_rd_idx_i,
   output logic                     res_valid_o,
   input  logic                     res_ready_i,
   output logic [XLEN-1:0]          res_data_o,
   output logic [REG_IDX_WIDTH-1:0] res_rd_idx_o,
   output logic                     busy_o
);

   localparam int NITER = XLEN / STEP;
   localparam int CNT_W = (NITER > 1) ? $clog2(NITER) : 1;

   md_state_e              state_q, state_d;
   logic [2:0]             fun3_q, fun3_d;
   logic [REG_IDX_WIDTH-1:0] rd_q, rd_d;
   logic [XLEN-1:0]        a_q, a_d;
   logic [XLEN:0]          rem_q, rem_d;
   logic [XLEN-1:0]        quo_q, quo_d;
   logic                   neg_q, neg_d;
   logic [CNT_W-1:0]       cnt_q, cnt_d;
   logic [XLEN-1:0]        res_q, res_d;

   logic                   s1, s2, is_div, is_rem, rs2_zero, div_ovf;
   logic [XLEN-1:0]        abs1, abs2;
   logic [2*XLEN-1:0]      prod_abs, prod_s;
   logic [XLEN-1:0]        quo_s, rem_s;

   logic [STEP:0][XLEN:0]   rem_c;
   logic [STEP:0][XLEN-1:0] quo_c;

   assign rem_c[0] = rem_q;
   assign quo_c[0] = quo_q;

   for (genvar g = 0; g < STEP; g++) begin : g_step
      ex_muldiv_step #(.XLEN(XLEN)) u_step (
         .mode_i (fun3_q[2]),
         .opd_i  (a_q),
         .rem_i  (rem_c[g]),
         .quo_i  (quo_c[g]),
         .rem_o  (rem_c[g+1]),
         .quo_o  (quo_c[g+1])
      );
   end

   always_comb begin
      s1       = rs1_is_signed(req_fun3_i) & req_rs1_i[XLEN-1];
      s2       = rs2_is_signed(req_fun3_i) & req_rs2_i[XLEN-1];
      abs1     = s1 ? -req_rs1_i : req_rs1_i;
      abs2     = s2 ? -req_rs2_i : req_rs2_i;
      is_div   = req_fun3_i[2];
      is_rem   = req_fun3_i[2] & req_fun3_i[1];
      rs2_zero = (req_rs2_i == '0);
      div_ovf  = (req_fun3_i == DIV || req_fun3_i == REM) &&
                 (req_rs1_i == {1'b1, {(XLEN-1){1'b0}}}) && (&req_rs2_i);
   end

   assign prod_abs = {rem_q[XLEN-1:0], quo_q};
   assign prod_s   = neg_q ? -prod_abs : prod_abs;
   assign quo_s    = neg_q ? -quo_q : quo_q;
   assign rem_s    = neg_q ? -rem_q[XLEN-1:0] : rem_q[XLEN-1:0];

   always_comb begin
      state_d = state_q;
      fun3_d  = fun3_q;
      rd_d    = rd_q;
      a_d     = a_q;
      rem_d   = rem_q;
      quo_d   = quo_q;
      neg_d   = neg_q;
      cnt_d   = cnt_q;
      res_d   = res_q;
      case (state_q)
         IDLE: begin
            if (req_valid_i && !flush_i) begin
               fun3_d = req_fun3_i;
               rd_d   = req_rd_idx_i;
               // the remainder takes the dividend's sign; everything else the xor
               neg_d  = (req_fun3_i == REM) ? s1 : (s1 ^ s2);
               a_d    = is_div ? abs2 : abs1;
               quo_d  = is_div ? abs1 : abs2;
               rem_d  = '0;
               cnt_d  = CNT_W'(NITER - 1);
               if (is_div && rs2_zero) begin
                  res_d   = is_rem ? req_rs1_i : '1;
                  state_d = DONE;
               end else if (div_ovf) begin
                  res_d   = is_rem ? '0 : req_rs1_i;
                  state_d = DONE;
               end else begin
                  state_d = CALC;
               end
            end
         end
         CALC: begin
            rem_d = rem_c[STEP];
            quo_d = quo_c[STEP];
            cnt_d = cnt_q - 1'b1;
            if (cnt_q == '0) state_d = FIX;
         end
         FIX: begin
            case (fun3_q)
               MUL:                  res_d = prod_s[XLEN-1:0];
               MULH, MULHSU, MULHU:  res_d = prod_s[2*XLEN-1:XLEN];
               DIV, DIVU:            res_d = quo_s;
               default:              res_d = rem_s;
            endcase
            state_d = DONE;
         end
         DONE: begin
            if (res_ready_i) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
      if (flush_i) state_d = IDLE;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         fun3_q  <= '0;
         rd_q    <= '0;
         a_q     <= '0;
         rem_q   <= '0;
         quo_q   <= '0;
         neg_q   <= 1'b0;
         cnt_q   <= '0;
         res_q   <= '0;
      end else begin
         state_q <= state_d;
         fun3_q  <= fun3_d;
         rd_q    <= rd_d;
         a_q     <= a_d;
         rem_q   <= rem_d;
         quo_q   <= quo_d;
         neg_q   <= neg_d;
         cnt_q   <= cnt_d;
         res_q   <= res_d;
      end
   end

   assign req_ready_o  = (state_q == IDLE);
   assign busy_o       = (state_q != IDLE);
   assign res_valid_o  = (state_q == DONE);
   assign res_data_o   = res_q;
   assign res_rd_idx_o = rd_q;

endmodule

// File: tb/tb_ex_muldiv.sv
// Directed bench for ex_muldiv: STEP=1 main instance plus a STEP=2 instance
// for the shortened-latency cases.
module tb_ex_muldiv;
   import ex_muldiv_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   always #5 clk = ~clk;

   logic        flush, req_valid, req_ready, res_valid, res_ready, busy;
   logic [2:0]  req_fun3;
   logic [31:0] req_rs1, req_rs2, res_data;
   logic [4:0]  req_rd, res_rd;

   logic        req_valid2, req_ready2, res_valid2, busy2;
   logic [2:0]  req_fun3_2;
   logic [31:0] req_rs1_2, req_rs2_2, res_data2;
   logic [4:0]  res_rd2;

   int n_vec = 0;
   int n_err = 0;

   ex_muldiv #(.XLEN(32), .REG_IDX_WIDTH(5), .STEP(1)) dut (
      .clk(clk), .rst_n(rst_n), .flush_i(flush),
      .req_valid_i(req_valid), .req_ready_o(req_ready), .req_fun3_i(req_fun3),
      .req_rs1_i(req_rs1), .req_rs2_i(req_rs2), .req_rd_idx_i(req_rd),
      .res_valid_o(res_valid), .res_ready_i(res_ready), .res_data_o(res_data),
      .res_rd_idx_o(res_rd), .busy_o(busy)
   );

   ex_muldiv #(.XLEN(32), .REG_IDX_WIDTH(5), .STEP(2)) dut2 (
      .clk(clk), .rst_n(rst_n), .flush_i(1'b0),
      .req_valid_i(req_valid2), .req_ready_o(req_ready2), .req_fun3_i(req_fun3_2),
      .req_rs1_i(req_rs1_2), .req_rs2_i(req_rs2_2), .req_rd_idx_i(5'd3),
      .res_valid_o(res_valid2), .res_ready_i(1'b1), .res_data_o(res_data2),
      .res_rd_idx_o(res_rd2), .busy_o(busy2)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Called at a negedge; returns at the negedge right after the accept edge.
   task automatic issue(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd);
      chk("req_ready_before_issue", {31'd0, req_ready}, 32'd1);
      req_fun3  = f;
      req_rs1   = a;
      req_rs2   = b;
      req_rd    = rd;
      req_valid = 1'b1;
      @(negedge clk);
      req_valid = 1'b0;
   endtask

   task automatic wait_res(output int lat);
      lat = 1;
      while (!res_valid && lat < 200) begin
         @(negedge clk);
         lat++;
      end
   endtask

   task automatic run_op(input string tag, input logic [2:0] f, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] rd,
                         input logic [31:0] exp_data, input int exp_lat);
      int lat;
      issue(f, a, b, rd);
      wait_res(lat);
      chk({tag, "_lat"}, 32'(lat), 32'(exp_lat));
      chk({tag, "_data"}, res_data, exp_data);
      chk({tag, "_rd"}, {27'd0, res_rd}, {27'd0, rd});
      @(negedge clk);
      chk({tag, "_valid_cleared"}, {31'd0, res_valid}, 32'd0);
   endtask

   initial begin
      int lat;
      flush = 0; req_valid = 0; res_ready = 1;
      req_fun3 = '0; req_rs1 = '0; req_rs2 = '0; req_rd = '0;
      req_valid2 = 0; req_fun3_2 = '0; req_rs1_2 = '0; req_rs2_2 = '0;

      @(negedge clk);
      chk("rst_ready",  {31'd0, req_ready}, 32'd1);
      chk("rst_busy",   {31'd0, busy}, 32'd0);
      chk("rst_valid",  {31'd0, res_valid}, 32'd0);
      chk("rst_data",   res_data, 32'd0);
      chk("rst_rd",     {27'd0, res_rd}, 32'd0);
      rst_n = 1'b1;
      @(negedge clk);
      chk("post_rst_ready", {31'd0, req_ready}, 32'd1);

      run_op("mul",    MUL,    32'd7,        32'hFFFFFFFD, 5'd5,  32'hFFFFFFEB, 34);
      run_op("mulh",   MULH,   32'h80000000, 32'h80000000, 5'd6,  32'h40000000, 34);
      run_op("mulhsu", MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd7,  32'hFFFFFFFF, 34);
      run_op("mulhu",  MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 5'd8,  32'hFFFFFFFE, 34);
      run_op("div_ovf", DIV,   32'h80000000, 32'hFFFFFFFF, 5'd9,  32'h80000000, 1);
      run_op("rem_ovf", REM,   32'h80000000, 32'hFFFFFFFF, 5'd10, 32'h00000000, 1);
      run_op("divu_z", DIVU,   32'd1234,     32'd0,        5'd11, 32'hFFFFFFFF, 1);
      run_op("remu_z", REMU,   32'd1234,     32'd0,        5'd12, 32'd1234,     1);
      run_op("div_neg", DIV,   32'hFFFFFFF9, 32'd2,        5'd13, 32'hFFFFFFFD, 34);
      run_op("rem_neg", REM,   32'hFFFFFFF9, 32'd2,        5'd14, 32'hFFFFFFFF, 34);
      run_op("divu",   DIVU,   32'd100,      32'd7,        5'd15, 32'd14,       34);
      run_op("remu",   REMU,   32'd100,      32'd7,        5'd16, 32'd2,        34);

      // abort a divide mid-flight
      issue(DIV, 32'd100, 32'd7, 5'd17);
      repeat (9) @(negedge clk);
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      chk("flush_busy",  {31'd0, busy}, 32'd0);
      chk("flush_ready", {31'd0, req_ready}, 32'd1);
      chk("flush_valid", {31'd0, res_valid}, 32'd0);

      // a request colliding with a flush is dropped
      req_fun3 = DIVU; req_rs1 = 32'd5; req_rs2 = 32'd0; req_valid = 1'b1; flush = 1'b1;
      @(negedge clk);
      req_valid = 1'b0; flush = 1'b0;
      chk("flush_drop_busy",  {31'd0, busy}, 32'd0);
      chk("flush_drop_valid", {31'd0, res_valid}, 32'd0);

      run_op("mul_after_flush", MUL, 32'd3, 32'd4, 5'd18, 32'd12, 34);

      // consumer stalls in DONE
      res_ready = 1'b0;
      issue(DIVU, 32'd100, 32'd7, 5'd19);
      wait_res(lat);
      chk("stall_lat",  32'(lat), 32'd34);
      chk("stall_data", res_data, 32'd14);
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         chk("stall_valid_held", {31'd0, res_valid}, 32'd1);
         chk("stall_data_held",  res_data, 32'd14);
         chk("stall_rd_held",    {27'd0, res_rd}, 32'd19);
         chk("stall_not_ready",  {31'd0, req_ready}, 32'd0);
      end
      res_ready = 1'b1;
      @(negedge clk);
      chk("stall_release_valid", {31'd0, res_valid}, 32'd0);
      chk("stall_release_ready", {31'd0, req_ready}, 32'd1);

      // STEP=2 instance
      chk("s2_ready", {31'd0, req_ready2}, 32'd1);
      req_fun3_2 = DIVU; req_rs1_2 = 32'd100; req_rs2_2 = 32'd7; req_valid2 = 1'b1;
      @(negedge clk);
      req_valid2 = 1'b0;
      lat = 1;
      while (!res_valid2 && lat < 200) begin
         @(negedge clk);
         lat++;
      end
      chk("s2_divu_lat",  32'(lat), 32'd18);
      chk("s2_divu_data", res_data2, 32'd14);
      chk("s2_divu_rd",   {27'd0, res_rd2}, 32'd3);
      @(negedge clk);

      req_fun3_2 = MUL; req_rs1_2 = 32'd7; req_rs2_2 = 32'hFFFFFFFD; req_valid2 = 1'b1;
      @(negedge clk);
      req_valid2 = 1'b0;
      lat = 1;
      while (!res_valid2 && lat < 200) begin
         @(negedge clk);
         lat++;
      end
      chk("s2_mul_lat",  32'(lat), 32'd18);
      chk("s2_mul_data", res_data2, 32'hFFFFFFEB);
      @(negedge clk);
      chk("s2_idle", {31'd0, busy2}, 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
